// File: rtl/control_puertas_pkg.sv
// control_puertas_pkg: state, motor and button codes shared by the elevator door controller.
package control_puertas_pkg;

  typedef enum logic [1:0] {
    CERRADA  = 2'b00,
    ABIERTA  = 2'b01,
    CERRANDO = 2'b10,
    ABRIENDO = 2'b11
  } estado_puertas_t;

  localparam logic [1:0] MOTOR_PARADO = 2'b00;
  localparam logic [1:0] MOTOR_ABRIR  = 2'b01;
  localparam logic [1:0] MOTOR_CERRAR = 2'b10;

  localparam logic [1:0] BOTON_NADA   = 2'b00;
  localparam logic [1:0] BOTON_CERRAR = 2'b01;
  localparam logic [1:0] BOTON_ABRIR  = 2'b10;

  // Code 11 is treated as open, so only the upper bit matters for open.
  function automatic logic boton_abrir(input logic [1:0] b);
    return (b & BOTON_ABRIR) != BOTON_NADA;
  endfunction

  function automatic logic boton_cerrar(input logic [1:0] b);
    return b == BOTON_CERRAR;
  endfunction

  function automatic logic [1:0] motor_de(input estado_puertas_t e);
    case (e)
      ABRIENDO: return MOTOR_ABRIR;
      CERRANDO: return MOTOR_CERRAR;
      default:  return MOTOR_PARADO;
    endcase
  endfunction

endpackage

// File: rtl/control_puertas_n_temporizador.sv
// temporizador_puertas: loadable down-counter shared by door travel and dwell timing.
module temporizador_puertas #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic [W-1:0] cuenta,
  output logic         cero,
  output logic         ultimo
);

  logic [W-1:0] cuenta_d;
  logic [W-1:0] cuenta_q;

  // next count: load wins, otherwise decrement and hold at zero
  always_comb begin
    cuenta_d = cuenta_q;
    if (carga) begin
      cuenta_d = valor;
    end else if (cuenta_q != {W{1'b0}}) begin
      cuenta_d = cuenta_q - W'(1'b1);
    end else begin
      cuenta_d = cuenta_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cuenta_q <= {W{1'b0}};
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cuenta = cuenta_q;
  assign cero   = (cuenta_q == {W{1'b0}});
  assign ultimo = (cuenta_q == W'(1'b1));

endmodule

// File: rtl/control_puertas_n.sv
// control_puertas_n: elevator car door controller (state machine, timing, chime, fault).
// Define CONTROL_PUERTAS_NUDGE_EN to enable the sensor-retry limit with nudge buzzer.
module control_puertas_n
  import control_puertas_pkg::*;
#(
  parameter int unsigned N_PISOS      = 4,
  parameter int unsigned T_MOV        = 20,
  parameter int unsigned T_ABIERTA    = 100,
  parameter int unsigned N_REINTENTOS = 3,
  localparam int unsigned PW          = $clog2(N_PISOS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PW-1:0]      piso,
  input  logic               moviendo,
  input  logic               subiendo,
  input  logic [N_PISOS-1:0] sol_cabina,
  input  logic [N_PISOS-1:0] sol_subir,
  input  logic [N_PISOS-1:0] sol_bajar,
  input  logic [1:0]         boton,
  input  logic               sensor,
  output logic [1:0]         estado_puertas,
  output logic [1:0]         motor_puertas,
  output logic [N_PISOS-1:0] aviso,
  output logic [N_PISOS-1:0] atendido,
  output logic               trabajando,
  output logic               fallo,
  output logic               zumbador
);

  localparam int unsigned T_MAX = (T_MOV > T_ABIERTA) ? T_MOV : T_ABIERTA;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned RW    = $clog2(N_REINTENTOS + 1);

  localparam logic [TW-1:0] T_MOV_L     = TW'(T_MOV);
  localparam logic [TW-1:0] T_ABIERTA_L = TW'(T_ABIERTA);
  localparam logic [RW-1:0] LIMITE      = RW'(N_REINTENTOS);
  localparam logic [PW:0]   N_PISOS_L   = (PW + 1)'(N_PISOS);

`ifdef CONTROL_PUERTAS_NUDGE_EN
  localparam logic NUDGE_EN = 1'b1;
`else
  localparam logic NUDGE_EN = 1'b0;
`endif

  estado_puertas_t    estado_d, estado_q;
  logic [1:0]         motor_d, motor_q;
  logic [N_PISOS-1:0] aviso_d, aviso_q;
  logic [N_PISOS-1:0] atendido_d, atendido_q;
  logic               trabajando_d, trabajando_q;
  logic               fallo_d, fallo_q;
  logic               zumbador_d, zumbador_q;
  logic [RW-1:0]      reint_d, reint_q;

  logic [N_PISOS-1:0] piso_oh_s;
  logic               piso_valido_s;
  logic               solicitado_s;
  logic               limite_s;
  logic               sensor_ef_s;
  logic               abrir_s;
  logic               carga_s;
  logic [TW-1:0]      valor_s;
  logic [TW-1:0]      cuenta_s;
  logic [TW-1:0]      transcurrido_s;
  logic               cero_s;
  logic               ultimo_s;
  logic               expira_s;

  temporizador_puertas #(
    .W (TW)
  ) u_temporizador (
    .clk    (clk),
    .rst    (rst),
    .carga  (carga_s),
    .valor  (valor_s),
    .cuenta (cuenta_s),
    .cero   (cero_s),
    .ultimo (ultimo_s)
  );

  // floor decode, request evaluation and effective open command
  always_comb begin
    piso_oh_s     = {{(N_PISOS - 1){1'b0}}, 1'b1} << piso;
    piso_valido_s = ({1'b0, piso} < N_PISOS_L);
    if (piso_valido_s) begin
      solicitado_s = (|(sol_cabina & piso_oh_s))
                   | (subiendo & (|(sol_subir & piso_oh_s)))
                   | (!subiendo & (|(sol_bajar & piso_oh_s)))
                   | ((piso == {PW{1'b0}}) & (|(sol_subir & piso_oh_s)))
                   | ((piso == PW'(N_PISOS - 1)) & (|(sol_bajar & piso_oh_s)));
    end else begin
      solicitado_s = 1'b0;
    end
    limite_s    = NUDGE_EN & (reint_q >= LIMITE);
    sensor_ef_s = sensor & ~limite_s;
    abrir_s     = boton_abrir(boton) | sensor_ef_s;
    expira_s    = cero_s | ultimo_s;
    // reopening takes as long as the doors have already been closing
    transcurrido_s = T_MOV_L - cuenta_s;
    if (transcurrido_s == {TW{1'b0}}) begin
      transcurrido_s = TW'(1'b1);
    end else begin
      transcurrido_s = T_MOV_L - cuenta_s;
    end
  end

  // door state machine and next values of the registered outputs
  always_comb begin
    estado_d   = estado_q;
    carga_s    = 1'b0;
    valor_s    = T_MOV_L;
    aviso_d    = {N_PISOS{1'b0}};
    atendido_d = {N_PISOS{1'b0}};
    reint_d    = reint_q;
    case (estado_q)
      CERRADA: begin
        if (!moviendo && solicitado_s) begin
          estado_d = ABRIENDO;
          carga_s  = 1'b1;
          valor_s  = T_MOV_L;
          aviso_d  = piso_oh_s;
        end else begin
          estado_d = CERRADA;
        end
      end
      ABRIENDO: begin
        if (expira_s) begin
          estado_d   = ABIERTA;
          carga_s    = 1'b1;
          valor_s    = T_ABIERTA_L;
          atendido_d = piso_oh_s;
        end else begin
          estado_d = ABRIENDO;
        end
      end
      ABIERTA: begin
        if (abrir_s) begin
          carga_s = 1'b1;
          valor_s = T_ABIERTA_L;
        end else if (boton_cerrar(boton) || expira_s) begin
          estado_d = CERRANDO;
          carga_s  = 1'b1;
          valor_s  = T_MOV_L;
        end else begin
          estado_d = ABIERTA;
        end
      end
      CERRANDO: begin
        if (abrir_s) begin
          estado_d = ABRIENDO;
          carga_s  = 1'b1;
          valor_s  = transcurrido_s;
          // only reversals caused by the sensor alone count toward the limit
          if (sensor_ef_s && !boton_abrir(boton) && (reint_q < LIMITE)) begin
            reint_d = reint_q + RW'(1'b1);
          end else begin
            reint_d = reint_q;
          end
        end else if (expira_s) begin
          estado_d = CERRADA;
        end else begin
          estado_d = CERRANDO;
        end
      end
      default: begin
        estado_d = CERRADA;
      end
    endcase
    if (estado_d == CERRADA) begin
      reint_d = {RW{1'b0}};
    end else begin
      reint_d = reint_d;
    end
    motor_d      = motor_de(estado_d);
    trabajando_d = (estado_d != CERRADA);
    fallo_d      = fallo_q | (moviendo & (estado_q != CERRADA)) | ~piso_valido_s;
    zumbador_d   = NUDGE_EN & (reint_d >= LIMITE) & (estado_d != CERRADA);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q     <= CERRADA;
      motor_q      <= MOTOR_PARADO;
      aviso_q      <= {N_PISOS{1'b0}};
      atendido_q   <= {N_PISOS{1'b0}};
      trabajando_q <= 1'b0;
      fallo_q      <= 1'b0;
      zumbador_q   <= 1'b0;
      reint_q      <= {RW{1'b0}};
    end else begin
      estado_q     <= estado_d;
      motor_q      <= motor_d;
      aviso_q      <= aviso_d;
      atendido_q   <= atendido_d;
      trabajando_q <= trabajando_d;
      fallo_q      <= fallo_d;
      zumbador_q   <= zumbador_d;
      reint_q      <= reint_d;
    end
  end

  assign estado_puertas = estado_q;
  assign motor_puertas  = motor_q;
  assign aviso          = aviso_q;
  assign atendido       = atendido_q;
  assign trabajando     = trabajando_q;
  assign fallo          = fallo_q;
  assign zumbador       = zumbador_q;

endmodule

// File: tb/tb_control_puertas_n.sv
// tb_control_puertas_n: directed stimulus with a queued expected-output scoreboard.
`timescale 1ns/1ps
module tb_control_puertas_n;
  import control_puertas_pkg::*;

  localparam int NP = 4;
  localparam int TM = 20;
  localparam int TA = 12;
  localparam int NR = 3;
`ifdef CONTROL_PUERTAS_NUDGE_EN
  localparam bit NUDGE = 1'b1;
`else
  localparam bit NUDGE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    piso;
  logic          moviendo;
  logic          subiendo;
  logic [NP-1:0] sol_cabina;
  logic [NP-1:0] sol_subir;
  logic [NP-1:0] sol_bajar;
  logic [1:0]    boton;
  logic          sensor;
  logic [1:0]    estado_puertas;
  logic [1:0]    motor_puertas;
  logic [NP-1:0] aviso;
  logic [NP-1:0] atendido;
  logic          trabajando;
  logic          fallo;
  logic          zumbador;
  logic [14:0]   observado;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } esperado_t;

  esperado_t cola[$];
  int evaluadas = 0;
  int fallos    = 0;

  always #5 clk = ~clk;

  control_puertas_n #(
    .N_PISOS      (NP),
    .T_MOV        (TM),
    .T_ABIERTA    (TA),
    .N_REINTENTOS (NR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .piso           (piso),
    .moviendo       (moviendo),
    .subiendo       (subiendo),
    .sol_cabina     (sol_cabina),
    .sol_subir      (sol_subir),
    .sol_bajar      (sol_bajar),
    .boton          (boton),
    .sensor         (sensor),
    .estado_puertas (estado_puertas),
    .motor_puertas  (motor_puertas),
    .aviso          (aviso),
    .atendido       (atendido),
    .trabajando     (trabajando),
    .fallo          (fallo),
    .zumbador       (zumbador)
  );

  assign observado = {estado_puertas, motor_puertas, aviso, atendido, trabajando, fallo, zumbador};

  // one clock: queue the expectation, advance, then pop and compare
  task automatic ciclo(input string tag, input logic [1:0] est, input logic [1:0] mot,
                       input logic [3:0] av, input logic [3:0] at, input logic fa, input logic zu);
    esperado_t e;
    esperado_t r;
    e.tag = tag;
    e.val = {est, mot, av, at, (est != 2'b00), fa, zu};
    cola.push_back(e);
    @(posedge clk);
    #1;
    r = cola.pop_front();
    evaluadas++;
    assert (observado === r.val)
    else begin
      fallos++;
      $error("FAIL %s: observed %h expected %h", r.tag, observado, r.val);
    end
  endtask

  // n cycles in one state; aviso/atendido pulses only on the first cycle
  task automatic fase(input string tag, input int n, input logic [1:0] est, input logic [1:0] mot,
                      input logic [3:0] av, input logic [3:0] at, input logic fa, input logic zu);
    for (int i = 0; i < n; i++) begin
      ciclo(tag, est, mot, (i == 0) ? av : 4'b0000, (i == 0) ? at : 4'b0000, fa, zu);
    end
  endtask

  initial begin
    rst = 1'b1; piso = 2'd0; moviendo = 1'b0; subiendo = 1'b0;
    sol_cabina = 4'b0000; sol_subir = 4'b0000; sol_bajar = 4'b0000;
    boton = 2'b00; sensor = 1'b0;
    fase("reset", 2, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    // floor 2 hall-up while travelling up: full open/dwell/close cycle
    piso = 2'd2; subiendo = 1'b1; sol_subir = 4'b0100;
    fase("abre_p2", 1, ABRIENDO, MOTOR_ABRIR, 4'b0100, 4'b0000, 1'b0, 1'b0);
    sol_subir = 4'b0000;
    fase("abriendo_p2", TM - 1, ABRIENDO, MOTOR_ABRIR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("abierta_p2", TA, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b0100, 1'b0, 1'b0);
    fase("cerrando_p2", TM, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("cerrada_p2", 2, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // hall-up at mid floor while going down is not a request
    subiendo = 1'b0; sol_subir = 4'b0100;
    fase("sin_solicitud", 3, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // top floor hall-down counts even while going up
    sol_subir = 4'b0000; piso = 2'd3; subiendo = 1'b1; sol_bajar = 4'b1000;
    fase("abre_p3", 1, ABRIENDO, MOTOR_ABRIR, 4'b1000, 4'b0000, 1'b0, 1'b0);
    sol_bajar = 4'b0000;
    fase("abriendo_p3", TM - 1, ABRIENDO, MOTOR_ABRIR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("abierta_p3", 1, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b1000, 1'b0, 1'b0);

    // close button cuts the dwell short
    boton = 2'b01;
    fase("boton_cerrar", 1, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    boton = 2'b00;
    fase("cerrando_pre", 5, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // sensor after 5 elapsed closing cycles: reopen for 5 cycles, no chime
    sensor = 1'b1;
    fase("sensor_rev", 1, ABRIENDO, MOTOR_ABRIR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    sensor = 1'b0;
    fase("reabriendo", 4, ABRIENDO, MOTOR_ABRIR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("reabierta", 5, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b1000, 1'b0, 1'b0);

    // open+close together: open wins and reloads the dwell
    boton = 2'b11;
    fase("boton_11", 1, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);
    boton = 2'b00;
    fase("dwell_recargado", TA - 1, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("cierre_dwell", 1, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // open button on the first closing cycle: minimum one-cycle reopen
    boton = 2'b10;
    fase("rev_minima", 1, ABRIENDO, MOTOR_ABRIR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    boton = 2'b00;
    fase("abierta_min", TA, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b1000, 1'b0, 1'b0);

    // in-car request raised while closing is ignored until one idle closed cycle
    sol_cabina = 4'b1000;
    fase("cerrando_ign", TM, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("ciclo_ocioso", 1, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("reabre_cabina", 1, ABRIENDO, MOTOR_ABRIR, 4'b1000, 4'b0000, 1'b0, 1'b0);
    sol_cabina = 4'b0000;
    fase("abriendo_cab", TM - 1, ABRIENDO, MOTOR_ABRIR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("abierta_cab", 1, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b1000, 1'b0, 1'b0);

    // motion with doors open is a sticky fault; reset clears everything
    moviendo = 1'b1;
    fase("fallo_set", 1, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b1, 1'b0);
    moviendo = 1'b0;
    fase("fallo_sticky", 2, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b1, 1'b0);
    rst = 1'b1;
    fase("rst_medio", 1, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    // moving while closed: no opening and no fault
    piso = 2'd1; sol_cabina = 4'b0010; moviendo = 1'b1;
    fase("moviendo_cerrada", 2, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);
    moviendo = 1'b0;
    fase("abre_p1", 1, ABRIENDO, MOTOR_ABRIR, 4'b0010, 4'b0000, 1'b0, 1'b0);
    sol_cabina = 4'b0000;
    fase("abriendo_p1", TM - 1, ABRIENDO, MOTOR_ABRIR, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fase("abierta_p1", TA, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b0010, 1'b0, 1'b0);
    fase("cerrando_p1", 1, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // repeated sensor reversals; with nudge the limit silences the sensor
    for (int i = 0; i < 4; i++) begin
      logic zr;
      logic ignora;
      zr     = NUDGE && (i >= 2);
      ignora = NUDGE && (i == 3);
      sensor = 1'b1;
      if (ignora) begin
        fase("sensor_ignorado", 1, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b1);
        sensor = 1'b0;
        fase("nudge_cierra", TM - 2, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b1);
        fase("nudge_cerrada", 1, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);
      end else begin
        fase("rev_sensor", 1, ABRIENDO, MOTOR_ABRIR, 4'b0000, 4'b0000, 1'b0, zr);
        sensor = 1'b0;
        fase("rev_abierta", TA, ABIERTA, MOTOR_PARADO, 4'b0000, 4'b0010, 1'b0, zr);
        fase("rev_cerrando", 1, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, zr);
      end
    end
    if (!NUDGE) begin
      fase("cierre_final", TM - 1, CERRANDO, MOTOR_CERRAR, 4'b0000, 4'b0000, 1'b0, 1'b0);
      fase("cerrada_final", 1, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    fase("reposo_final", 2, CERRADA, MOTOR_PARADO, 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluadas, fallos);
    $finish;
  end

endmodule
